mul_hilo_ctrl: RTL and testbench

Sequential control stage wrapped around the combinational 32x32 signed array multiplier in the execute path.
- Accepts a multiply request from decode and registers the operands onto the multiplier inputs.
- Holds them for a fixed multicycle settle window, then captures the 64-bit product into HI/LO registers.
- Writes the result back to the register file as one word (FS=11110) or two words (FS=11111).

---
 rtl/mul_hilo_ctrl_pkg.sv | 23 ++
 rtl/mul_wb_seq.sv | 59 +++++
 rtl/mul_hilo_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared constants, function-select encodings and FSM state type for the
// mul_hilo_ctrl multiply control stage.
package mul_hilo_ctrl_pkg;

    localparam int MUL_DATA_W     = 32;
    localparam int MUL_REG_ADDR_W = 5;
    localparam int MUL_CNT_W      = 4;

    localparam logic [4:0] FS_MUL_LO   = 5'b11110;
    localparam logic [4:0] FS_MUL_HILO = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WB_LO = 2'd2,
        ST_WB_HI = 2'd3
    } state_e;

    function automatic logic is_mul_fs(input logic [4:0] f);
        return (f == FS_MUL_LO) || (f == FS_MUL_HILO);
    endfunction

endpackage

// File: rtl/mul_wb_seq.sv
// Write-back sequencer: presents LO (and optionally HI at rd+1) to the
// register file, holding address/data stable until wb_ready_i.
module mul_wb_seq
    import mul_hilo_ctrl_pkg::*;
#(
    parameter int DATA_W     = MUL_DATA_W,
    parameter int REG_ADDR_W = MUL_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  abort_i,
    input  logic                  two_word_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0]     lo_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic                  wb_ready_i,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0]     wb_data_o
);

    logic                  valid_q;
    logic                  hi_phase_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            hi_phase_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else if (abort_i) begin
            // A handshake in this same cycle still completes at the register file.
            valid_q    <= 1'b0;
            hi_phase_q <= 1'b0;
        end else if (load_i) begin
            valid_q    <= 1'b1;
            hi_phase_q <= 1'b0;
            addr_q     <= rd_i;
            data_q     <= lo_i;
        end else if (valid_q && wb_ready_i) begin
            if (!hi_phase_q && two_word_i) begin
                hi_phase_q <= 1'b1;
                addr_q     <= addr_q + 1'b1;
                data_q     <= hi_i;
            end else begin
                valid_q    <= 1'b0;
                hi_phase_q <= 1'b0;
            end
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_addr_o  = addr_q;
    assign wb_data_o  = data_q;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Multicycle control around a combinational signed multiplier: registers
// operands, waits MUL_LATENCY cycles, captures HI/LO and writes back.
// Optional MUL_ZERO_BYPASS_EN: zero operand skips the settle window.
module mul_hilo_ctrl
    import mul_hilo_ctrl_pkg::*;
#(
    parameter int DATA_W      = MUL_DATA_W,
    parameter int REG_ADDR_W  = MUL_REG_ADDR_W,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ready,
    input  logic [4:0]            fs,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  flush,
    output logic [DATA_W-1:0]     mul_a,
    output logic [DATA_W-1:0]     mul_b,
    output logic [4:0]            mul_fs,
    input  logic [2*DATA_W-1:0]   mul_product,
    input  logic                  mul_c,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic                  carry,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    input  logic                  wb_ready,
    output logic                  busy
);

    localparam logic [MUL_CNT_W-1:0] CNT_LOAD = MUL_CNT_W'(MUL_LATENCY - 1);

    state_e                state_q;
    logic [MUL_CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0]     mul_a_q;
    logic [DATA_W-1:0]     mul_b_q;
    logic [4:0]            mul_fs_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     hi_q;
    logic [DATA_W-1:0]     lo_q;
    logic                  carry_q;
    logic                  ready_q;

    logic                  accept;
    logic                  bypass;
    logic                  capture;
    logic                  abort;
    logic [DATA_W-1:0]     seq_lo;

`ifdef MUL_ZERO_BYPASS_EN
    assign bypass = (op_a == '0) || (op_b == '0);
`else
    assign bypass = 1'b0;
`endif

    assign accept  = start && ready_q && is_mul_fs(fs);
    assign capture = (state_q == ST_WAIT) && (cnt_q == '0) && !flush;
    assign abort   = flush && (state_q != ST_IDLE);
    // The only load from IDLE is the zero-bypass path, whose product is 0.
    assign seq_lo  = (state_q == ST_IDLE) ? '0 : mul_product[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            mul_fs_q <= '0;
            rd_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            carry_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mul_a_q  <= op_a;
                        mul_b_q  <= op_b;
                        mul_fs_q <= fs;
                        rd_q     <= rd;
                        ready_q  <= 1'b0;
                        if (bypass) begin
                            hi_q    <= '0;
                            lo_q    <= '0;
                            carry_q <= 1'b0;
                            state_q <= ST_WB_LO;
                        end else begin
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b1;
                        mul_fs_q <= '0;
                    end else if (cnt_q == '0) begin
                        {hi_q, lo_q} <= mul_product;
                        carry_q      <= mul_c;
                        state_q      <= ST_WB_LO;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WB_LO: begin
                    if (flush || (wb_ready && mul_fs_q != FS_MUL_HILO)) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b1;
                        mul_fs_q <= '0;
                    end else if (wb_ready) begin
                        state_q <= ST_WB_HI;
                    end
                end
                ST_WB_HI: begin
                    if (flush || wb_ready) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b1;
                        mul_fs_q <= '0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ready_q  <= 1'b1;
                    mul_fs_q <= '0;
                end
            endcase
        end
    end

    mul_wb_seq #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_wb_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (capture || (accept && bypass)),
        .abort_i    (abort),
        .two_word_i (mul_fs_q == FS_MUL_HILO),
        .rd_i       (rd_q),
        .lo_i       (seq_lo),
        .hi_i       (hi_q),
        .wb_ready_i (wb_ready),
        .wb_valid_o (wb_valid),
        .wb_addr_o  (wb_addr),
        .wb_data_o  (wb_data)
    );

    assign ready  = ready_q;
    assign busy   = ~ready_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign mul_fs = mul_fs_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Scoreboard bench for mul_hilo_ctrl: directed multiplies with hand-computed
// write-back words and cycle timing; a negedge monitor pops and compares.
module tb_mul_hilo_ctrl;

    localparam int LAT = 4;
`ifdef MUL_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = LAT + 1;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic [4:0]  fs = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic [31:0] mul_a, mul_b;
    logic [4:0]  mul_fs;
    logic [63:0] mul_product;
    logic        mul_c;
    logic [31:0] hi, lo;
    logic        carry;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready = 1'b1;
    logic        busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];

    mul_hilo_ctrl #(.DATA_W(32), .REG_ADDR_W(5), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .fs(fs),
        .op_a(op_a), .op_b(op_b), .rd(rd), .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_fs(mul_fs),
        .mul_product(mul_product), .mul_c(mul_c),
        .hi(hi), .lo(lo), .carry(carry),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_ready(wb_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment model of the signed array multiplier.
    always_comb begin
        mul_product = '0;
        if (mul_fs != 5'd0)
            mul_product = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        mul_c = mul_product[63];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] f, input logic [4:0] r);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        fs    = f;
        rd    = r;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_ready",    64'(ready),    64'd1);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_addr",  64'(wb_addr),  64'd0);
        check("rst_wb_data",  64'(wb_data),  64'd0);
        check("rst_hilo",     {hi, lo},      64'd0);
        check("rst_carry",    64'(carry),    64'd0);
        check("rst_mul_ab",   {mul_a, mul_b}, 64'd0);
        check("rst_mul_fs",   64'(mul_fs),   64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected (cycle %0d)",
                         wb_addr, wb_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("[TB] write cycle %0d addr %0d data 0x%08h", cyc, wb_addr, wb_data);
                check("wb_addr",  64'(wb_addr), 64'(e.addr));
                check("wb_data",  64'(wb_data), 64'(e.data));
                check("wb_cycle", 64'(cyc),     64'(e.cyc));
            end
        end
    end

    initial begin
        int acc;
        repeat (3) tick();
        check_reset_state();
        rst_n = 1'b1;
        tick();

        // 1: 3 * -5, single word
        acc = cyc;
        push(5'd4, 32'hFFFF_FFF1, acc + LAT + 1);
        issue(32'd3, 32'hFFFF_FFFB, 5'b11110, 5'd4);
        check("t1_mul_a",  64'(mul_a),  64'd3);
        check("t1_mul_b",  64'(mul_b),  64'hFFFF_FFFB);
        check("t1_mul_fs", 64'(mul_fs), 64'h1E);
        check("t1_busy",   64'(busy),   64'd1);
        wait_cyc(acc + LAT + 1);
        check("t1_ready_in_wb", 64'(ready), 64'd0);
        tick();
        check("t1_ready_back", 64'(ready), 64'd1);
        check("t1_hi",    64'(hi),    64'hFFFF_FFFF);
        check("t1_lo",    64'(lo),    64'hFFFF_FFF1);
        check("t1_carry", 64'(carry), 64'd1);
        check("t1_mul_fs_idle", 64'(mul_fs), 64'd0);
        check("t1_mul_a_hold",  64'(mul_a),  64'd3);

        // Non-multiply FS is ignored
        issue(32'd9, 32'd9, 5'b00101, 5'd2);
        check("bad_fs_ready",  64'(ready),  64'd1);
        check("bad_fs_mul_fs", 64'(mul_fs), 64'd0);

        // 2: max positive squared, two words with rd wrap
        acc = cyc;
        push(5'd31, 32'h0000_0001, acc + LAT + 1);
        push(5'd0,  32'h3FFF_FFFF, acc + LAT + 2);
        issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'b11111, 5'd31);
        wait_ready();
        check("t2_hi",    64'(hi),    64'h3FFF_FFFF);
        check("t2_carry", 64'(carry), 64'd0);

        // 3: -1 * -1 with a 3-cycle write-back stall
        wb_ready = 1'b0;
        acc = cyc;
        push(5'd8, 32'd1, acc + LAT + 4);
        push(5'd9, 32'd0, acc + LAT + 5);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b11111, 5'd8);
        wait_cyc(acc + LAT + 1);
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", 64'(wb_valid), 64'd1);
            check("t3_hold_addr",  64'(wb_addr),  64'd8);
            check("t3_hold_data",  64'(wb_data),  64'd1);
            tick();
        end
        wb_ready = 1'b1;
        wait_ready();

        // 4: flush in WAIT, plus a start while busy
        acc = cyc;
        issue(32'd2, 32'd3, 5'b11111, 5'd5);
        issue(32'd5, 32'd5, 5'b11110, 5'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_ready_after_flush", 64'(ready), 64'd1);
        check("t4_mul_fs_cleared",    64'(mul_fs), 64'd0);
        check("t4_mul_a_first_req",   64'(mul_a),  64'd2);
        for (int i = 0; i < 8; i++) begin
            check("t4_no_wb_valid", 64'(wb_valid), 64'd0);
            tick();
        end
        check("t4_hilo_kept", {hi, lo}, 64'd1);

        // 5: reset during WB_HI
        acc = cyc;
        push(5'd10, 32'd6, acc + LAT + 1);
        issue(32'd2, 32'd3, 5'b11111, 5'd10);
        wait_cyc(acc + LAT + 2);
        check("t5_whi_valid", 64'(wb_valid), 64'd1);
        check("t5_whi_addr",  64'(wb_addr),  64'd11);
        check("t5_whi_data",  64'(wb_data),  64'd0);
        wb_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_state();
        tick();
        tick();
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t5_no_wb_after_rst", 64'(wb_valid), 64'd0);
            tick();
        end

        // 6: zero operand
        acc = cyc;
        push(5'd3, 32'd0, acc + ZLAT);
        issue(32'd0, 32'd7, 5'b11110, 5'd3);
        check("t6_mul_b", 64'(mul_b), 64'd7);
        wait_ready();
        check("t6_hilo",  {hi, lo},   64'd0);
        check("t6_carry", 64'(carry), 64'd0);

        repeat (3) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
